// File: rtl/nes_bus_pkg.sv
// ============================================================================
// nes_bus_pkg : CPU/PPU bus address constants and OAM DMA state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nes_bus_pkg;

  localparam logic [15:0] PPU_OAMDATA = 16'h2004;
  localparam logic [15:0] OAM_DMA     = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
// oam_dma : sprite DMA, halts the CPU and copies one 256-byte page to OAMDATA
// Revision: 1.0
// ============================================================================
`default_nettype none

module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAM_DMA,
  parameter logic [15:0] OAMDATA_ADDR = PPU_OAMDATA,
  parameter bit          ALIGN_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_wr,
  input  logic [7:0]  bus_data_rd,
  output logic        halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_data_wr
);

  dma_state_t state;
  dma_state_t next_state;

  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic       p;
  logic       trigger;

  // Only an observed-IDLE write can start a transfer, so a write landing on
  // the final WRITE edge is dropped.
  assign trigger = (state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= 1'b0;
    end else begin
      state <= next_state;
      p     <= ~p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
    end else begin
      if (trigger) begin
        page <= cpu_data_wr;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        data_q <= bus_data_rd;
      end
      if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    halt        = 1'b1;
    dma_addr    = 16'h0000;
    dma_rw      = 1'b1;
    dma_data_wr = 8'h00;
    case (state)
      IDLE: begin
        halt = 1'b0;
        if (trigger) begin
          next_state = HALT;
        end
      end
      HALT: begin
        // p is 1 now means the next cycle is a get cycle, so reads line up.
        if (p || !ALIGN_ENABLE) begin
          next_state = READ;
        end else begin
          next_state = ALIGN;
        end
      end
      ALIGN: begin
        next_state = READ;
      end
      READ: begin
        dma_addr   = {page, idx};
        next_state = WRITE;
      end
      WRITE: begin
        dma_addr    = OAMDATA_ADDR;
        dma_rw      = 1'b0;
        dma_data_wr = data_q;
        next_state  = (idx == 8'hFF) ? IDLE : READ;
      end
      default: begin
        halt       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  assign dma_active = halt;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
// tb_oam_dma : scoreboard bench for oam_dma (aligned and non-aligned builds)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_oam_dma;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_data_wr = 8'h00;

  logic        halt_a, active_a, rw_a;
  logic [15:0] addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        halt_b, active_b, rw_b;
  logic [15:0] addr_b;
  logic [7:0]  wdata_b, rdata_b;

  // Memory model: every byte holds the complement of its low address byte.
  assign rdata_a = ~addr_a[7:0];
  assign rdata_b = ~addr_b[7:0];

  oam_dma dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_data_wr(cpu_data_wr), .bus_data_rd(rdata_a), .halt(halt_a),
    .dma_active(active_a), .dma_addr(addr_a), .dma_rw(rw_a), .dma_data_wr(wdata_a)
  );

  oam_dma #(.ALIGN_ENABLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_data_wr(cpu_data_wr), .bus_data_rd(rdata_b), .halt(halt_b),
    .dma_active(active_b), .dma_addr(addr_b), .dma_rw(rw_b), .dma_data_wr(wdata_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int          len_q[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic        p_m;

  // Reference get/put parity.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_m <= 1'b0;
    else        p_m <= ~p_m;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops scoreboard entries as the DUT issues bus cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("active_eq_halt", active_a, halt_a);
        if (active_a && !rw_a) begin
          check_eq("wr_addr", addr_a, OAM_DMA - 16'h4014 + PPU_OAMDATA);
          if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
          else                  check_eq("wr_data", wdata_a, wr_q.pop_front());
        end
        if (active_a && rw_a && addr_a != 16'h0000) begin
          if (rd_q.size() == 0) check_eq("rd_unexpected", 1, 0);
          else                  check_eq("rd_addr", addr_a, rd_q.pop_front());
        end
        if (halt_a) begin
          cnt_a++;
        end else if (cnt_a > 0) begin
          if (len_q.size() == 0) check_eq("len_unexpected", 1, 0);
          else                   check_eq("halt_len_a", cnt_a, len_q.pop_front());
          check_eq("idle_addr", addr_a, 16'h0000);
          check_eq("idle_rw", rw_a, 1'b1);
          cnt_a = 0;
        end
        if (halt_b) begin
          cnt_b++;
        end else if (cnt_b > 0) begin
          check_eq("halt_len_noalign", cnt_b, 513);
          cnt_b = 0;
        end
      end
    end
  end

  task automatic push_xfer(input logic [7:0] pg);
    len_q.push_back((p_m == 1'b0) ? 513 : 514);
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({pg, i[7:0]});
      wr_q.push_back(~i[7:0]);
    end
  endtask

  // Called at a negedge: drives a one-cycle CPU bus access.
  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_addr = a; cpu_rw = rw; cpu_data_wr = d;
    @(negedge clk);
    cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_data_wr = 8'h00;
  endtask

  task automatic trig(input logic [7:0] pg);
    push_xfer(pg);
    cpu_cycle(OAM_DMA, 1'b0, pg);
    check_eq("halt_rise", halt_a, 1'b1);
  endtask

  task automatic start(input logic [7:0] pg, input logic want_p);
    @(negedge clk);
    if (p_m != want_p) @(negedge clk);
    trig(pg);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((halt_a || halt_b) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1500) check_eq("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_read(input logic [15:0] target);
    int n = 0;
    while (!(active_a && rw_a && addr_a == target) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1500) check_eq("read_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_halt", halt_a, 1'b0);
    check_eq("rst_active", active_a, 1'b0);
    check_eq("rst_addr", addr_a, 16'h0000);
    check_eq("rst_rw", rw_a, 1'b1);
    check_eq("rst_wdata", wdata_a, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Get-cycle start, put-cycle start, page wrap.
    start(8'h02, 1'b0); wait_idle();
    start(8'h02, 1'b1); wait_idle();
    start(8'hFF, 1'b0); wait_idle();

    // A CPU read of the trigger register does nothing.
    cpu_cycle(OAM_DMA, 1'b1, 8'h07);
    repeat (10) @(negedge clk);
    check_eq("read_no_trig", halt_a, 1'b0);

    // Second write mid-transfer is ignored; page stays $02.
    start(8'h02, 1'b0);
    wait_read(16'h0240);
    cpu_cycle(OAM_DMA, 1'b0, 8'h05);
    wait_idle();

    // Trigger in the first IDLE cycle after completion starts a new transfer.
    start(8'h02, 1'b0);
    wait_read(16'h02FF);
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b_idle_gap", halt_a, 1'b0);
    trig(8'h03);
    wait_idle();

    // Trigger coincident with the final WRITE edge is dropped.
    start(8'h02, 1'b0);
    wait_read(16'h02FF);
    @(negedge clk);
    cpu_cycle(OAM_DMA, 1'b0, 8'h09);
    check_eq("coinc_ignored", halt_a, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("coinc_still_idle", halt_a, 1'b0);
    wait_idle();

    // Asynchronous reset mid-transfer.
    start(8'h02, 1'b0);
    wait_read(16'h0280);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_halt", halt_a, 1'b0);
    check_eq("arst_active", active_a, 1'b0);
    check_eq("arst_rw", rw_a, 1'b1);
    check_eq("arst_addr", addr_a, 16'h0000);
    rd_q.delete(); wr_q.delete(); len_q.delete();
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("arst_no_resume", halt_a, 1'b0);

    check_eq("rd_q_left", rd_q.size(), 0);
    check_eq("wr_q_left", wr_q.size(), 0);
    check_eq("len_q_left", len_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine triggered by a CPU write to $4014. It sits on the CPU bus between the CPU and the PPU register port.
- It halts the CPU and copies 256 bytes from CPU page $XX00-$XXFF into the PPU via repeated writes to OAMDATA ($2004).
- It owns the bus address, direction and write data while active. The top level muxes these onto the PPU/mmap bus in place of the CPU's signals.
- It runs in the clk_cpu domain.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers a transfer.
- OAMDATA_ADDR, 16'h2004, destination address for every DMA write cycle.
- ALIGN_ENABLE, 1, 1 = insert the extra alignment cycle when a transfer starts on a put cycle; 0 = never align.

Ports:
- clk  in  1  CPU clock (clk_cpu).
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  CPU direction, 1 = read, 0 = write.
- cpu_data_wr  in  8  CPU write data (page number on trigger).
- bus_data_rd  in  8  bus read data returned for DMA read cycles.
- halt  out  1  CPU stall; high in every non-IDLE state.
- dma_active  out  1  bus select for the top-level mux; identical timing to halt.
- dma_addr  out  16  DMA bus address.
- dma_rw  out  1  DMA bus direction.
- dma_data_wr  out  8  DMA write data.

Behaviour:
- **Clock and reset:** single clock; reset is asynchronous and active-low (rst_n).
- **Parity bit p:** p = 0 at reset and toggles every clk.
  - p = 0 marks a get (read) cycle; p = 1 marks a put cycle.
- **Trigger:** cpu_rw == 0 and cpu_addr == DMA_REG_ADDR while the FSM is in IDLE.
  - On the trigger edge, page <= cpu_data_wr, idx <= 0, state <= HALT.
  - The CPU's own write cycle completes normally; halt rises the following cycle.
- **States and transitions:**
  - IDLE: wait for trigger.
  - HALT: one dummy cycle, no bus drive (dma_rw = 1, dma_addr = 0). Next state is READ if the next cycle is a get cycle; otherwise ALIGN (ALIGN_ENABLE = 1) or READ (ALIGN_ENABLE = 0).
  - ALIGN: one dummy cycle, no bus drive; then READ.
  - READ: dma_addr = {page, idx}, dma_rw = 1. On the edge, data_q <= bus_data_rd; next state WRITE.
  - WRITE: dma_addr = OAMDATA_ADDR, dma_rw = 0, dma_data_wr = data_q. On the edge, idx <= idx + 1 (8-bit wrap). If idx == 8'hFF, go to IDLE; otherwise go to READ.
- **Output timing:** all outputs are Moore outputs, decoded from registered state/page/idx/data_q only; there is no comb path from inputs to outputs.
- **Transfer length:** halt/dma_active stay high for 513 cycles when the first cycle after HALT is a get cycle, else 514 cycles (ALIGN_ENABLE = 1). There are exactly 256 READ/WRITE pairs in order idx 0..255.
- **Reset values:** state = IDLE, page = 0, idx = 0, data_q = 0, p = 0. Outputs: halt = 0, dma_active = 0, dma_addr = 0, dma_rw = 1, dma_data_wr = 0.
- **IDLE outputs:** dma_addr = 0, dma_rw = 1, dma_data_wr = 0.
- **Boundary conditions:**
  - A trigger while not IDLE is ignored; page is not re-latched.
  - A read of DMA_REG_ADDR (cpu_rw = 1) never triggers.
  - Page $FF wraps idx only; the address never exceeds $FFFF.
  - A trigger on the same edge the FSM returns to IDLE is ignored. The FSM must be observed in IDLE to trigger.
  - A trigger in the cycle immediately after returning to IDLE starts a new transfer.
  - Reset mid-transfer aborts immediately: outputs return to reset values asynchronously and the partial transfer is not resumed.
  - Page values that target PPU/IO space ($20-$3F) get no special handling; they are read as issued.

Decomposition:
- Shared package nes_bus_pkg holds:
  - address constants PPU_OAMDATA = 16'h2004 and OAM_DMA = 16'h4014;
  - the typedef enum dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
- No sub-module; this is one FSM plus page/idx/data/parity registers.

Test Plan:
- **Trigger on a get cycle:** write $02 to $4014 such that the cycle after HALT has p = 0 -> halt high exactly 513 cycles. Read addresses $0200..$02FF ascending, each followed by a write to $2004. Memory preloaded with byte = ~addr[7:0] -> 256 writes of $FF,$FE,...,$00.
- **Trigger on a put cycle:** same write one cycle later -> one ALIGN cycle, halt high 514 cycles, identical data sequence. With ALIGN_ENABLE = 0 -> 513 cycles.
- **Page wrap:** write $FF -> last read address $FFFF; FSM returns to IDLE with dma_addr = 0 and halt = 0 the next cycle.
- **Ignored triggers:**
  - A CPU read of $4014 -> no transfer.
  - A write of $05 to $4014 at idx = $40 -> page stays $02; still 256 writes total.
- **Reset mid-transfer:** assert rst_n low at idx = $80 -> halt, dma_active and dma_rw return to 0/0/1 without waiting for clk. After release, no further $2004 writes until a new trigger.
- **Back-to-back triggers:**
  - A trigger on the cycle immediately after completion -> a second full 513/514-cycle transfer.
  - A trigger coincident with the final WRITE edge -> ignored.
